// File: rtl/btn_pkg.sv
// Shared definitions for the button event path: FSM encoding, counter width, default timings.
// Latency: n/a (declarations only).
// Backpressure: n/a; event consumers must accept one-cycle pulses.
package btn_pkg;

  localparam int BTN_CNT_W = 25;

  // Defaults tuned for a 27 MHz clock, kept alongside the debouncer tuning.
  localparam logic [BTN_CNT_W-1:0] LONG_CNT_DEF   = 25'd13500000; // 0.5 s
  localparam logic [BTN_CNT_W-1:0] REPEAT_CNT_DEF = 25'd2700000;  // 0.1 s
  localparam logic [BTN_CNT_W-1:0] DBL_CNT_DEF    = 25'd8100000;  // 0.3 s

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

endpackage

// File: rtl/btn_event_timer.sv
// Cycle counter with synchronous clear/enable and a terminal-count flag (count == limit-1).
// Latency: tc is combinational from the registered count; count updates one edge after en.
// Backpressure: none; the owner clears the counter on every hit so it never wraps.
module btn_event_timer
  import btn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [BTN_CNT_W-1:0] limit,
  output logic                 tc
);

  logic [BTN_CNT_W-1:0] count;

  // Count up while enabled; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == (limit - 1'b1));

endmodule

// File: rtl/btn_event_decoder.sv
// Turns a debounced active-low button level into press/release/long/repeat pulses (+ double-click with BTN_EVENT_DBL_EN).
// Latency: every event registers on the edge that samples the qualifying edge or count (1 cycle after btn moves).
// Backpressure: none; all outputs are single-cycle registered pulses, plus the held level.
module btn_event_decoder
  import btn_pkg::*;
#(
  parameter logic [BTN_CNT_W-1:0] LONG_CNT   = LONG_CNT_DEF,
  parameter logic [BTN_CNT_W-1:0] REPEAT_CNT = REPEAT_CNT_DEF
`ifdef BTN_EVENT_DBL_EN
  ,
  parameter logic [BTN_CNT_W-1:0] DBL_CNT    = DBL_CNT_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt_press,
  output logic evt_release,
  output logic evt_long,
  output logic evt_repeat,
`ifdef BTN_EVENT_DBL_EN
  output logic evt_dbl,
`endif
  output logic held
);

  // Thresholds below 2 would make the terminal count collide with the clear value.
  if (LONG_CNT < 2) begin : g_bad_long
    $error("btn_event_decoder: LONG_CNT must be >= 2");
  end
  if (REPEAT_CNT < 2) begin : g_bad_repeat
    $error("btn_event_decoder: REPEAT_CNT must be >= 2");
  end

  state_t               state;
  logic                 btn_q;
  logic                 fall;
  logic                 rise;
  logic                 hold_clr;
  logic                 hold_en;
  logic                 hold_tc;
  logic [BTN_CNT_W-1:0] hold_limit;

  assign fall = ~btn & btn_q;
  assign rise = btn & ~btn_q;

  // One counter serves both phases: it times LONG_CNT in PRESSED, then REPEAT_CNT periods in HELD.
  assign hold_en    = (state != IDLE);
  assign hold_clr   = (state == IDLE) | rise | hold_tc;
  assign hold_limit = (state == HELD) ? REPEAT_CNT : LONG_CNT;

  btn_event_timer u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (hold_clr),
    .en    (hold_en),
    .limit (hold_limit),
    .tc    (hold_tc)
  );

  // Main FSM; release wins over a coincident threshold hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      btn_q       <= 1'b1;
      evt_press   <= 1'b0;
      evt_release <= 1'b0;
      evt_long    <= 1'b0;
      evt_repeat  <= 1'b0;
      held        <= 1'b0;
    end else begin
      btn_q       <= btn;
      evt_press   <= 1'b0;
      evt_release <= 1'b0;
      evt_long    <= 1'b0;
      evt_repeat  <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            evt_press <= 1'b1;
            held      <= 1'b1;
            state     <= PRESSED;
          end
        end
        PRESSED: begin
          if (rise) begin
            evt_release <= 1'b1;
            held        <= 1'b0;
            state       <= IDLE;
          end else if (hold_tc) begin
            evt_long <= 1'b1;
            state    <= HELD;
          end
        end
        HELD: begin
          if (rise) begin
            evt_release <= 1'b1;
            held        <= 1'b0;
            state       <= IDLE;
          end else if (hold_tc) begin
            evt_repeat <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BTN_EVENT_DBL_EN
  logic armed;
  logic win_tc;

  // Window counter idles at zero while disarmed, so arming loads it with 0.
  btn_event_timer u_dbl_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (~armed),
    .en    (armed),
    .limit (DBL_CNT),
    .tc    (win_tc)
  );

  // Double-click tracking: only a short press arms; a fall while armed fires and disarms.
  // The window is dropped at DBL_CNT-1, so while armed the count is always below DBL_CNT.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed   <= 1'b0;
      evt_dbl <= 1'b0;
    end else begin
      evt_dbl <= 1'b0;
      if ((state == IDLE) && fall && armed) begin
        evt_dbl <= 1'b1;
        armed   <= 1'b0;
      end else if ((state == PRESSED) && rise) begin
        armed <= 1'b1;
      end else if (armed && win_tc) begin
        armed <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// Randomised scoreboard bench for btn_event_decoder.
// Expected event pulses and held intervals are derived from press/gap durations.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_btn_event_decoder;

  localparam int LONG = 10;
  localparam int REP  = 4;
  localparam int DBL  = 6;
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b1;
  logic evt_press, evt_release, evt_long, evt_repeat, held;
  logic evt_dbl_w;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  bit mon_en   = 1'b0;
  int last_rel = -1;

  typedef struct { int cyc; logic [4:0] mask; } exp_t;
  typedef struct { int s; int e; } iv_t;
  exp_t eq[$];
  iv_t  hq[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  btn_event_decoder #(
    .LONG_CNT   (25'(LONG)),
    .REPEAT_CNT (25'(REP))
`ifdef BTN_EVENT_DBL_EN
    ,
    .DBL_CNT    (25'(DBL))
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .evt_press   (evt_press),
    .evt_release (evt_release),
    .evt_long    (evt_long),
    .evt_repeat  (evt_repeat),
`ifdef BTN_EVENT_DBL_EN
    .evt_dbl     (evt_dbl_w),
`endif
    .held        (held)
  );

`ifndef BTN_EVENT_DBL_EN
  assign evt_dbl_w = 1'b0;
`endif

  // mask bits: 0 press, 1 release, 2 long, 3 repeat, 4 dbl
  task automatic push_evt(input int c, input logic [4:0] m);
    exp_t x;
    x.cyc = c; x.mask = m;
    eq.push_back(x);
  endtask

  // Button goes low right after edge s for L edges; nothing at or after edge 'cut' happens (reset).
  task automatic push_seg(input int s, input int L, input int cut);
    int p, r, t;
    logic [4:0] m;
    iv_t iv;
    p = s + 1;
    r = s + L + 1;
    m = 5'b00001;
`ifdef BTN_EVENT_DBL_EN
    if (last_rel >= 0 && (p - last_rel) <= DBL) m = m | 5'b10000;
`endif
    last_rel = -1;
    push_evt(p, m);
    t = p + LONG;
    if (t < r) begin
      if (t < cut) push_evt(t, 5'b00100);
      for (t = t + REP; t < r && t < cut; t = t + REP) push_evt(t, 5'b01000);
    end
    if (r < cut) begin
      push_evt(r, 5'b00010);
      if (L <= LONG) last_rel = r;
    end
    iv.s = p;
    iv.e = (r < cut) ? r - 1 : cut - 1;
    hq.push_back(iv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input int L, input int H);
    push_seg(edge_n, L, NEVER);
    btn = 1'b0;
    repeat (L) step();
    btn = 1'b1;
    repeat (H) step();
  endtask

  // Reset pulse on the 7th cycle of a hold; button stays low through it.
  task automatic reset_hold(input int L2, input int H);
    int s;
    s = edge_n;
    push_seg(s, NEVER / 2, s + 8);
    btn = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_rel = -1;
    push_seg(edge_n, L2, NEVER);
    repeat (L2) step();
    btn = 1'b1;
    repeat (H) step();
  endtask

  // Monitor: compare the event vector on any cycle where either side has a pulse, and held every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      int n;
      logic [4:0] act, expm;
      logic eh;
      n = edge_n;
      act = {evt_dbl_w, evt_repeat, evt_long, evt_release, evt_press};
      expm = 5'b0;
      while (eq.size() > 0 && eq[0].cyc < n) begin
        checks++; failures++;
        $display("FAIL missed_event cyc=%0d actual=none required=%b", eq[0].cyc, eq[0].mask);
        void'(eq.pop_front());
      end
      if (eq.size() > 0 && eq[0].cyc == n) expm = eq.pop_front().mask;
      if (act != 5'b0 || expm != 5'b0) begin
        checks++;
        if (act != expm) begin
          failures++;
          $display("FAIL events cyc=%0d actual=%b required=%b", n, act, expm);
        end
      end
      while (hq.size() > 0 && hq[0].e < n) void'(hq.pop_front());
      eh = (hq.size() > 0 && hq[0].s <= n && n <= hq[0].e);
      checks++;
      if (held !== eh) begin
        failures++;
        $display("FAIL held cyc=%0d actual=%b required=%b", n, held, eh);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] rv;
    repeat (3) step();
    rv = {evt_press, evt_release, evt_long, evt_repeat, held, evt_dbl_w};
    checks++;
    if (rv !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b required=000000", rv);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (20) step();          // idle: nothing may fire
    seg(1, 4);                   // 1-cycle press
    seg(5, 4);                   // short press
    seg(25, 4);                  // long + repeats
    seg(LONG, 12);               // rise on the long-threshold edge
    reset_hold(12, 10);          // reset mid-hold, btn still low
    seg(3, 2);  seg(3, 12);      // double-click inside window
    seg(3, 7);  seg(3, 12);      // gap too long
    seg(3, DBL); seg(3, 12);     // last cycle of window
    seg(3, 1);  seg(3, 1); seg(3, 12);
    seg(12, 2); seg(3, 12);      // release after long never arms
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 15) == 0)
        reset_hold($urandom_range(1, 20), $urandom_range(1, 9));
      else
        seg($urandom_range(1, 30), $urandom_range(1, 9));
    end
    repeat (30) step();
    checks++;
    if (eq.size() != 0) begin
      failures++;
      $display("FAIL leftover_events actual=%0d required=0", eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
